demux32_8: RTL and testbench



---
 rtl/demux32_8_pkg.sv | 13 +
 rtl/demux32_8_word_fifo2.sv | 46 ++++
 rtl/demux32_8.sv | 114 +++++++++++
 tb/tb_demux32_8.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/demux32_8_pkg.sv
// Shared definitions for the byte/word packer and serializer pair.
package demux32_8_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } ser_state_t;

endpackage

// File: rtl/demux32_8_word_fifo2.sv
// Two-entry first-word-fall-through word buffer: rdata always shows the head.
module word_fifo2
  import demux32_8_pkg::*;
(
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [1:0]        count
);

  logic [WORD_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Self-guarded so a misbehaving caller cannot corrupt the pointers.
  assign push_ok = push && (count != 2'd2);
  assign pop_ok  = pop && (count != 2'd0);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_4f) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/demux32_8.sv
// Word-to-byte serializer: buffers up to two 32-bit words and emits each as
// four consecutive bytes on clk_4f, gapless while words keep arriving.
module demux32_8
  import demux32_8_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic              clk_4f,
  input  logic              reset_L,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out
);

  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] word_p0;
  logic [WORD_W-1:0] fifo_rdata;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              last_byte;
  logic              push;
  logic              load;
  logic              advance;
  logic              drain;

  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx);
    logic [1:0] lane;
    lane = (MSB_FIRST != 0) ? (2'd3 - idx) : idx;
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  // ready_out deliberately ignores a same-cycle pop so it stays a pure
  // function of registered occupancy.
  assign ready_out  = (fifo_count < 2'd2) && reset_L;
  assign push       = valid_in && ready_out;
  assign fifo_empty = (fifo_count == 2'd0);
  assign last_byte  = (byte_idx == 2'd3);

  word_fifo2 u_fifo (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .push    (push),
    .pop     (load),
    .wdata   (data_in),
    .rdata   (fifo_rdata),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SERIAL;
      SERIAL:  if (last_byte && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    drain   = 1'b0;
    case (state)
      IDLE:    load = !fifo_empty;
      SERIAL: begin
        if (!last_byte)       advance = 1'b1;
        else if (!fifo_empty) load    = 1'b1;
        else                  drain   = 1'b1;
      end
      default: drain = 1'b1;
    endcase
  end

  // Stage p0: word held for serialization; not reset, only sampled on a pop.
  always_ff @(posedge clk_4f) begin
    if (load) word_p0 <= fifo_rdata;
  end

  // Output stage: byte counter and registered byte/valid.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      byte_idx  <= 2'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      byte_idx  <= 2'd0;
      data_out  <= pick_byte(fifo_rdata, 2'd0);
      valid_out <= 1'b1;
    end else if (advance) begin
      byte_idx  <= byte_idx + 2'd1;
      data_out  <= pick_byte(word_p0, byte_idx + 2'd1);
      valid_out <= 1'b1;
    end else if (drain) begin
      byte_idx  <= 2'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux32_8.sv
// Scoreboard bench for demux32_8: both byte orders run side by side against a
// word-queue reference model; a loopback phase checks the restored byte stream.
module tb_demux32_8;

  logic        clk_4f  = 1'b0;
  logic        reset_L = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        valid_in = 1'b0;

  logic        rdy_m, vout_m, rdy_l, vout_l;
  logic [7:0]  dout_m, dout_l;

  int tests = 0;
  int fails = 0;

  logic [7:0] lb_src[$];
  logic [7:0] lb_out[$];
  bit         lb_on = 1'b0;

  always #5 clk_4f = ~clk_4f;

  demux32_8 #(.MSB_FIRST(1)) dut_msb (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_m), .data_out(dout_m), .valid_out(vout_m)
  );

  demux32_8 #(.MSB_FIRST(0)) dut_lsb (
    .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy_l), .data_out(dout_l), .valid_out(vout_l)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Byte i (0 = first on the wire) of a word, by plain shifting.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i, input bit msb);
    int sh;
    sh = msb ? 8 * (3 - i) : 8 * i;
    return 8'((w >> sh) & 32'hFF);
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_chk
    localparam bit MSB = (d == 0);
    logic [7:0] dout;
    logic       vout, rdy;
    logic [7:0] exp_q[$];
    int         m_words = 0;
    int         m_left  = 0;
    int         pre;
    logic       m_valid = 1'b0;

    assign dout = (d == 0) ? dout_m : dout_l;
    assign vout = (d == 0) ? vout_m : vout_l;
    assign rdy  = (d == 0) ? rdy_m  : rdy_l;

    // Reference: words waiting, bytes left in the word on display, and the
    // queue of every byte still owed by accepted words.
    always @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
        exp_q.delete();
        m_words = 0;
        m_left  = 0;
        m_valid = 1'b0;
      end else begin
        pre = m_words;
        if (m_left == 0) begin
          if (pre > 0) begin
            m_words--;
            m_left  = 3;
            m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end else begin
          m_left--;
          m_valid = 1'b1;
        end
        if (valid_in && pre < 2) begin
          m_words++;
          for (int i = 0; i < 4; i++) exp_q.push_back(byte_of(data_in, i, MSB));
        end
      end
    end

    always @(negedge clk_4f) begin
      chk($sformatf("ready_out[%0d]", d), {31'b0, rdy},
          {31'b0, (reset_L && m_words < 2)});
      chk($sformatf("valid_out[%0d]", d), {31'b0, vout}, {31'b0, m_valid});
      if (vout) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("byte_underrun[%0d]", d), {24'b0, dout}, 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("data_out[%0d]", d), {24'b0, dout}, {24'b0, exp_q.pop_front()});
        end
        if (d == 0 && lb_on) lb_out.push_back(dout);
      end else begin
        chk($sformatf("idle_data_out[%0d]", d), {24'b0, dout}, 32'h0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_4f);
      #1;
    end
  endtask

  // Holds valid_in high until the word is taken; leaves valid_in asserted.
  task automatic send_word(input logic [31:0] w);
    bit r;
    int n;
    valid_in = 1'b1;
    data_in  = w;
    n = 0;
    do begin
      @(negedge clk_4f);
      r = rdy_m;
      @(posedge clk_4f);
      #1;
      n++;
    end while (!r && n < 40);
    chk("send_word_accepted", {31'b0, r}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] steps[3];
    steps[0] = 8'h2F; steps[1] = 8'h37; steps[2] = 8'h8A;

    repeat (3) @(negedge clk_4f);
    chk("reset_data_out", {24'b0, dout_m}, 32'h0);
    chk("reset_ready_out", {31'b0, rdy_m}, 32'h0);
    reset_L = 1'b1;
    idle(1);

    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b0;
      data_in  = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h1234_5678;
      idle(1);
    end

    send_word(32'hDEAD_BEEF);
    valid_in = 1'b0;
    idle(6);

    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    send_word(32'h090A_0B0C);
    valid_in = 1'b0;
    idle(14);

    // Reset mid-word with a second word queued.
    send_word(32'hDEAD_BEEF);
    send_word(32'h1122_3344);
    valid_in = 1'b0;
    idle(1);
    chk("pre_reset_byte", {24'b0, dout_m}, 32'hAD);
    reset_L = 1'b0;
    #1;
    chk("async_reset_data_msb", {24'b0, dout_m}, 32'h0);
    chk("async_reset_valid_msb", {31'b0, vout_m}, 32'h0);
    chk("async_reset_ready_msb", {31'b0, rdy_m}, 32'h0);
    chk("async_reset_data_lsb", {24'b0, dout_l}, 32'h0);
    chk("async_reset_valid_lsb", {31'b0, vout_l}, 32'h0);
    repeat (2) @(negedge clk_4f);
    reset_L = 1'b1;
    idle(8);

    for (int i = 0; i < 400; i++) begin
      valid_in = ($urandom_range(0, 2) != 0);
      data_in  = $urandom;
      idle(1);
    end
    valid_in = 1'b0;
    idle(14);

    // Loopback: byte stream as a packer would pack it, first byte in [31:24].
    b = 8'h10;
    for (int i = 0; i < 32; i++) begin
      lb_src.push_back(b);
      b = b + steps[i % 3];
    end
    lb_out.delete();
    lb_on = 1'b1;
    for (int w = 0; w < 8; w++) begin
      send_word({lb_src[4*w], lb_src[4*w+1], lb_src[4*w+2], lb_src[4*w+3]});
      valid_in = 1'b0;
      idle($urandom_range(0, 3));
    end
    idle(14);
    lb_on = 1'b0;
    chk("loopback_len", lb_out.size(), lb_src.size());
    for (int i = 0; i < 32 && i < lb_out.size(); i++)
      chk($sformatf("loopback_byte%0d", i), {24'b0, lb_out[i]}, {24'b0, lb_src[i]});

    chk("drain_msb", g_chk[0].exp_q.size(), 0);
    chk("drain_lsb", g_chk[1].exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
